// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ALU opcodes, forwarding selects,
// branch conditions and the ID/EX control payload.
package riscv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned REG_W    = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Non-datapath fields carried through the ID/EX register; all-zero is a bubble.
    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [2:0]       funct3;
        logic [2:0]       alu_control;
        logic [1:0]       result_src;
        logic             alu_src;
        logic             mem_write;
        logic             reg_write;
        logic             branch;
        logic             jump;
    } idex_ctrl_t;

endpackage

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: reset beats clr beats load; loads every cycle.
module id_ex_register
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc4_d,
    input  idex_ctrl_t      ctrl_d,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc4_e,
    output idex_ctrl_t      ctrl_e
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            rd1_e  <= '0;
            rd2_e  <= '0;
            imm_e  <= '0;
            pc_e   <= '0;
            pc4_e  <= '0;
            ctrl_e <= '0;
        end else begin
            rd1_e  <= rd1_d;
            rd2_e  <= rd2_d;
            imm_e  <= imm_d;
            pc_e   <= pc_d;
            pc4_e  <= pc4_d;
            ctrl_e <= ctrl_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX register, operand forwarding, ALU,
// branch/jal resolution and PC redirect request.
module ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [XLEN-1:0]  RD1,
    input  logic [XLEN-1:0]  RD2,
    input  logic [XLEN-1:0]  ImmD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCplus4D,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdD,
    input  logic [2:0]       Funct3D,
    input  logic [2:0]       ALUControlD,
    input  logic [1:0]       ResultSrcD,
    input  logic             ALUSrcD,
    input  logic             MemWriteD,
    input  logic             RegWriteD,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [XLEN-1:0]  ResultW,
    input  logic [XLEN-1:0]  ALUResultM,
    output logic [XLEN-1:0]  ALUResultE,
    output logic [XLEN-1:0]  WriteDataE,
    output logic [XLEN-1:0]  PCTargetE,
    output logic [XLEN-1:0]  PCplus4E,
    output logic [REG_W-1:0] RdE,
    output logic [REG_W-1:0] Rs1E,
    output logic [REG_W-1:0] Rs2E,
    output logic [1:0]       ResultSrcE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             PCSrcE
);

    idex_ctrl_t      ctrl_d;
    idex_ctrl_t      ctrl_e;
    logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e;
    logic [XLEN-1:0] src_a, src_b;
    logic [4:0]      shamt;
    logic            lt_s, lt_u, eq, cond;

    always_comb begin
        ctrl_d             = '0;
        ctrl_d.rs1         = Rs1D;
        ctrl_d.rs2         = Rs2D;
        ctrl_d.rd          = RdD;
        ctrl_d.funct3      = Funct3D;
        ctrl_d.alu_control = ALUControlD;
        ctrl_d.result_src  = ResultSrcD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.branch      = BranchD;
        ctrl_d.jump        = JumpD;
    end

    id_ex_register #(.XLEN(XLEN)) u_id_ex (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .rd1_d  (RD1),
        .rd2_d  (RD2),
        .imm_d  (ImmD),
        .pc_d   (PCD),
        .pc4_d  (PCplus4D),
        .ctrl_d (ctrl_d),
        .rd1_e  (rd1_e),
        .rd2_e  (rd2_e),
        .imm_e  (imm_e),
        .pc_e   (pc_e),
        .pc4_e  (PCplus4E),
        .ctrl_e (ctrl_e)
    );

    // Forwarding muxes; the reserved select 11 falls back to the register value.
    always_comb begin
        src_a = rd1_e;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = rd1_e;
        endcase
        WriteDataE = rd2_e;
        case (ForwardBE)
            FWD_WB:  WriteDataE = ResultW;
            FWD_MEM: WriteDataE = ALUResultM;
            default: WriteDataE = rd2_e;
        endcase
        src_b = ctrl_e.alu_src ? imm_e : WriteDataE;
    end

    assign shamt = src_b[4:0];
    assign lt_s  = $signed(src_a) < $signed(src_b);
    assign lt_u  = src_a < src_b;
    assign eq    = src_a == src_b;

    always_comb begin
        ALUResultE = '0;
        case (ctrl_e.alu_control)
            ALU_ADD: ALUResultE = src_a + src_b;
            ALU_SUB: ALUResultE = src_a - src_b;
            ALU_AND: ALUResultE = src_a & src_b;
            ALU_OR:  ALUResultE = src_a | src_b;
            ALU_XOR: ALUResultE = src_a ^ src_b;
            ALU_SLT: ALUResultE = XLEN'(lt_s);
            ALU_SLL: ALUResultE = src_a << shamt;
            ALU_SRL: ALUResultE = src_a >> shamt;
            default: ALUResultE = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (ctrl_e.funct3)
            BR_EQ:   cond = eq;
            BR_NE:   cond = !eq;
            BR_LT:   cond = lt_s;
            BR_GE:   cond = !lt_s;
            BR_LTU:  cond = lt_u;
            BR_GEU:  cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

    assign PCTargetE  = pc_e + imm_e;
    assign PCSrcE     = (ctrl_e.branch & cond) | ctrl_e.jump;
    assign RdE        = ctrl_e.rd;
    assign Rs1E       = ctrl_e.rs1;
    assign Rs2E       = ctrl_e.rs2;
    assign ResultSrcE = ctrl_e.result_src;
    assign RegWriteE  = ctrl_e.reg_write;
    assign MemWriteE  = ctrl_e.mem_write;

endmodule
